// File: rtl/uart_rx_ctrl.sv
// UART receive controller: synchronises rx, finds start bits and times the
// start/data/stop sampling points, delivering each byte with a one-cycle strobe.
module uart_rx_ctrl #(
  parameter int unsigned CLK_DIV   = 16,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 valid_n;
  logic                 frame_err_n;
  logic                 busy_n;

  logic rx_meta;
  logic rx_s;
  logic rx_s_d;
  logic fall_edge;
  logic sample;

  // Two-flop synchroniser plus edge history; all idle-high out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  // A held-low line (break, or low after a framing error) has no high-to-low edge.
  assign fall_edge = rx_s_d & ~rx_s;
  assign sample    = (cnt == '0);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shreg     <= shreg_n;
      data      <= data_n;
      valid     <= valid_n;
      frame_err <= frame_err_n;
      busy      <= busy_n;
    end
  end

  // Next-state and output decode; the line is sampled when the counter hits 0.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    idx_n       = idx;
    shreg_n     = shreg;
    data_n      = data;
    valid_n     = 1'b0;
    frame_err_n = 1'b0;

    case (state)
      IDLE: begin
        if (fall_edge) begin
          state_n = START;
          cnt_n   = HALF_LOAD;
        end
      end

      START: begin
        if (sample) begin
          if (!rx_s) begin
            state_n = DATA;
            cnt_n   = FULL_LOAD;
            idx_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end

      DATA: begin
        if (sample) begin
          // LSB arrives first, so shifting in at the MSB leaves bit 0 at the bottom.
          shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
          cnt_n   = FULL_LOAD;
          if (idx == LAST_IDX) begin
            state_n = STOP;
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end

      STOP: begin
        if (sample) begin
          state_n = IDLE;
          if (rx_s) begin
            data_n  = shreg;
            valid_n = 1'b1;
          end else begin
            frame_err_n = 1'b1;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl at CLK_DIV=16, DATA_BITS=8.
module tb_uart_rx_ctrl;

  localparam int unsigned CLK_DIV   = 16;
  localparam int unsigned DATA_BITS = 8;
  // rx driven at cycle N reaches rx_s at N+2 (T); valid appears at T+153.
  localparam int VALID_LAT = 155;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 rx;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 frame_err;
  logic                 busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  int          v_cyc[$];
  logic [7:0]  v_dat[$];
  int          e_cyc[$];
  int          both_cnt = 0;
  int          long_cnt = 0;
  logic        prev_v   = 1'b0;
  logic        prev_e   = 1'b0;

  uart_rx_ctrl #(
    .CLK_DIV  (CLK_DIV),
    .DATA_BITS(DATA_BITS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse recorder: logs strobes with their cycle number and pulse-rule breaches.
  always @(negedge clk) begin
    if (valid) begin
      v_cyc.push_back(cyc);
      v_dat.push_back(data);
    end
    if (frame_err) e_cyc.push_back(cyc);
    if (valid && frame_err) both_cnt++;
    if ((valid && prev_v) || (frame_err && prev_e)) long_cnt++;
    prev_v = valid;
    prev_e = frame_err;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    v_cyc.delete();
    v_dat.delete();
    e_cyc.delete();
  endtask

  task automatic bit_time(input logic v);
    rx = v;
    repeat (CLK_DIV) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, output int t0);
    t0 = cyc;
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) tick();
    tests++;
    if ({data, valid, frame_err, busy} !== 11'd0) begin
      fails++;
      $display("FAIL reset_hold: data=%h valid=%b ferr=%b busy=%b, want all 0",
               data, valid, frame_err, busy);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      tests++;
      if ({data, valid, frame_err, busy} !== 11'd0) begin
        fails++;
        $display("FAIL idle_%0d: data=%h valid=%b ferr=%b busy=%b, want all 0",
                 i, data, valid, frame_err, busy);
      end
    end
  endtask

  task automatic test_single_byte();
    int t0;
    clear_mon();
    send_byte(8'hA5, 1'b1, t0);
    repeat (2) tick();
    tests++;
    if (v_cyc.size() != 1) begin
      fails++;
      $display("FAIL a5_count: got %0d valid pulses, want 1", v_cyc.size());
    end else begin
      tests++;
      if (v_cyc[0] != t0 + VALID_LAT) begin
        fails++;
        $display("FAIL a5_time: valid at %0d, want %0d", v_cyc[0], t0 + VALID_LAT);
      end
      tests++;
      if (v_dat[0] !== 8'hA5) begin
        fails++;
        $display("FAIL a5_data: got %h, want a5", v_dat[0]);
      end
    end
    tests++;
    if (e_cyc.size() != 0) begin
      fails++;
      $display("FAIL a5_ferr: got %0d frame_err pulses, want 0", e_cyc.size());
    end
    tests++;
    if (busy !== 1'b0 || data !== 8'hA5) begin
      fails++;
      $display("FAIL a5_after: busy=%b data=%h, want busy=0 data=a5", busy, data);
    end
  endtask

  task automatic test_glitch();
    int  t0;
    logic exp_busy;
    clear_mon();
    t0 = cyc;
    rx = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (i == 4) rx = 1'b1;
      tick();
      exp_busy = (cyc >= t0 + 3) && (cyc <= t0 + 10);
      tests++;
      if (busy !== exp_busy) begin
        fails++;
        $display("FAIL glitch_busy@%0d: busy=%b, want %b", cyc - t0, busy, exp_busy);
      end
    end
    tests++;
    if (v_cyc.size() != 0 || e_cyc.size() != 0 || data !== 8'hA5) begin
      fails++;
      $display("FAIL glitch_out: valid=%0d ferr=%0d data=%h, want 0/0/a5",
               v_cyc.size(), e_cyc.size(), data);
    end
  endtask

  task automatic test_frame_error();
    int t0;
    int t1;
    clear_mon();
    send_byte(8'h3C, 1'b0, t0);
    for (int i = 0; i < 40; i++) begin
      tick();
      tests++;
      if (busy !== 1'b0) begin
        fails++;
        $display("FAIL held_low_busy@%0d: busy=%b, want 0", i, busy);
      end
    end
    rx = 1'b1;
    repeat (20) tick();
    tests++;
    if (e_cyc.size() != 1) begin
      fails++;
      $display("FAIL ferr_count: got %0d frame_err pulses, want 1", e_cyc.size());
    end else begin
      tests++;
      if (e_cyc[0] != t0 + VALID_LAT) begin
        fails++;
        $display("FAIL ferr_time: frame_err at %0d, want %0d", e_cyc[0], t0 + VALID_LAT);
      end
    end
    tests++;
    if (v_cyc.size() != 0 || data !== 8'hA5) begin
      fails++;
      $display("FAIL ferr_data: valid=%0d data=%h, want 0 pulses data=a5", v_cyc.size(), data);
    end
    clear_mon();
    send_byte(8'h5A, 1'b1, t1);
    repeat (2) tick();
    tests++;
    if (v_cyc.size() != 1 || e_cyc.size() != 0) begin
      fails++;
      $display("FAIL 5a_count: valid=%0d ferr=%0d, want 1/0", v_cyc.size(), e_cyc.size());
    end else begin
      tests++;
      if (v_cyc[0] != t1 + VALID_LAT || v_dat[0] !== 8'h5A) begin
        fails++;
        $display("FAIL 5a_data: at %0d data=%h, want at %0d data=5a",
                 v_cyc[0], v_dat[0], t1 + VALID_LAT);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    int t1;
    clear_mon();
    send_byte(8'h00, 1'b1, t0);
    send_byte(8'hFF, 1'b1, t1);
    repeat (2) tick();
    tests++;
    if (v_cyc.size() != 2 || e_cyc.size() != 0) begin
      fails++;
      $display("FAIL b2b_count: valid=%0d ferr=%0d, want 2/0", v_cyc.size(), e_cyc.size());
    end else begin
      tests++;
      if (v_cyc[0] != t0 + VALID_LAT || v_cyc[1] != t0 + VALID_LAT + 160) begin
        fails++;
        $display("FAIL b2b_time: valid at %0d,%0d, want %0d,%0d", v_cyc[0], v_cyc[1],
                 t0 + VALID_LAT, t0 + VALID_LAT + 160);
      end
      tests++;
      if (v_dat[0] !== 8'h00 || v_dat[1] !== 8'hFF) begin
        fails++;
        $display("FAIL b2b_data: got %h,%h, want 00,ff", v_dat[0], v_dat[1]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int t1;
    clear_mon();
    bit_time(1'b0);
    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b0);
    rx = 1'b0;
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if ({data, valid, frame_err, busy} !== 11'd0) begin
        fails++;
        $display("FAIL midrst_%0d: data=%h valid=%b ferr=%b busy=%b, want all 0",
                 i, data, valid, frame_err, busy);
      end
      tick();
    end
    rx    = 1'b1;
    rst_n = 1'b1;
    repeat (20) tick();
    tests++;
    if (v_cyc.size() != 0 || e_cyc.size() != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL midrst_abort: valid=%0d ferr=%0d busy=%b, want 0/0/0",
               v_cyc.size(), e_cyc.size(), busy);
    end
    send_byte(8'h81, 1'b1, t1);
    repeat (2) tick();
    tests++;
    if (v_cyc.size() != 1 || e_cyc.size() != 0) begin
      fails++;
      $display("FAIL 81_count: valid=%0d ferr=%0d, want 1/0", v_cyc.size(), e_cyc.size());
    end else begin
      tests++;
      if (v_cyc[0] != t1 + VALID_LAT || v_dat[0] !== 8'h81) begin
        fails++;
        $display("FAIL 81_data: at %0d data=%h, want at %0d data=81",
                 v_cyc[0], v_dat[0], t1 + VALID_LAT);
      end
    end
  endtask

  task automatic test_pulse_rules();
    tests++;
    if (both_cnt != 0) begin
      fails++;
      $display("FAIL exclusive: valid and frame_err together %0d times, want 0", both_cnt);
    end
    tests++;
    if (long_cnt != 0) begin
      fails++;
      $display("FAIL pulse_width: %0d multi-cycle pulses, want 0", long_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    test_reset_mid_frame();
    test_pulse_rules();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
